// File: rtl/mdu_pkg.sv
// Shared op codes, default latencies and op classification for the multiply/divide unit.
// MDU_MADD_EN enables the accumulate ops (MADD/MADDU/MSUB/MSUBU).
package mdu_defs;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    // Ops that occupy the unit for a multi-cycle latency.
    function automatic logic mdu_is_long(input logic [3:0] op);
        logic r;
        r = (op >= 4'd1) && (op <= 4'd4);
`ifdef MDU_MADD_EN
        r = r || ((op >= 4'd9) && (op <= 4'd12));
`endif
        return r;
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage operand/control bundle into the MDU and HI/LO/busy back out.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOP;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDUOP, start, input busy, HI, LO);
    modport slave  (input A, B, MDUOP, start, output busy, HI, LO);
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: operands, op and current {HI,LO} to the 64-bit {HI,LO} result.
// MDU_MADD_EN adds the accumulate ops; otherwise they fall through to keep {HI,LO}.
module mdu_arith
    import mdu_defs::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic [63:0] hilo,
    output logic [63:0] res
);

    logic [63:0] prod_s, prod_u;
    logic        sgn, a_neg, b_neg;
    logic [31:0] dvd, dvs, q_mag, r_mag, q, r;

    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // One unsigned divider on magnitudes serves both DIV and DIVU; signs fixed up after.
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 with no special case.
    assign sgn   = (op == MDU_DIV);
    assign a_neg = sgn & a[31];
    assign b_neg = sgn & b[31];
    assign dvd   = a_neg ? -a : a;
    assign dvs   = b_neg ? -b : b;
    assign q_mag = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
    assign r_mag = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
    assign q     = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign r     = a_neg ? -r_mag : r_mag;

    always_comb begin
        res = hilo;
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV,
            MDU_DIVU:  if (b != 32'd0) res = {r, q};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = hilo + prod_s;
            MDU_MADDU: res = hilo + prod_u;
            MDU_MSUB:  res = hilo - prod_s;
            MDU_MSUBU: res = hilo - prod_u;
`endif
            default:   res = hilo;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: fixed-latency ops into private HI/LO, plus MTHI/MTLO.
// MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU at MUL_CYCLES latency.
module mdu
    import mdu_defs::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [63:0]   pending;
    logic [31:0]   hi, lo;
    logic          busy_q;
    logic [63:0]   res;

    // Result is computed from the operands and {HI,LO} present at start and held in pending.
    mdu_arith u_arith (
        .a    (bus.A),
        .b    (bus.B),
        .op   (bus.MDUOP),
        .hilo ({hi, lo}),
        .res  (res)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            hi      <= '0;
            lo      <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    if (mdu_is_long(bus.MDUOP)) begin
                        pending <= res;
                        cnt     <= mdu_is_div(bus.MDUOP) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        state   <= BUSY;
                        busy_q  <= 1'b1;
                    end else if (bus.MDUOP == MDU_MTHI) begin
                        hi <= bus.A;
                    end else if (bus.MDUOP == MDU_MTLO) begin
                        lo <= bus.A;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        {hi, lo} <= pending;
                        state    <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.HI   = hi;
    assign bus.LO   = lo;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage, beside the ALU, fed by the same forwarded rs/rt operands. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency into private HI/LO registers and services MTHI/MTLO writes. It raises `busy` so the hazard unit can stall later multiply/divide-class instructions. HI/LO are read combinationally for MFHI/MFLO, and the EX-stage result mux selects them alongside ALUOUT.

## Interface
- MUL_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-class when enabled); must be ≥1
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be ≥1
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- MDUOP  in  4  operation code from EX control
- start  in  1  EX instruction is valid, not stalled, not flushed; qualifies MDUOP this cycle
- busy  out  1  operation in flight
- HI  out  32  HI register, direct register output
- LO  out  32  LO register, direct register output

## Operation
- Op codes: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO. MFHI/MFLO cause no state change.
- FSM: IDLE, BUSY. Counter width is $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
- IDLE, start, and op 1–4: capture the 64-bit result into a pending register, load the counter with N (MUL_CYCLES or DIV_CYCLES), and go to BUSY.
- BUSY: decrement each cycle. When the counter equals 1, write pending {HI,LO}, then return to IDLE.
- IDLE, start, and MTHI: HI←A. MTLO: LO←A. Single edge, no busy.
- start while BUSY is ignored. The hazard unit guarantees it never occurs, and a bench asserts it.
- MULT: {HI,LO} = signed 64-bit A×B. MULTU: unsigned A×B.
- DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B = 0): the op still runs its full DIV_CYCLES. HI and LO are left unchanged.
- Reset values: HI = 0, LO = 0, busy = 0, FSM = IDLE, counter = 0, pending = 0.
- Reset mid-operation: the op is aborted with no writeback, and busy drops immediately (async).

## Timing
- start sampled at edge E0 for op 1–4: busy is high from E0 to edge E0+N, i.e. exactly N cycles.
- HI/LO take the new value at edge E0+N. busy is low in the same cycle.
- MFHI/MFLO issued in the cycle after busy falls read the new value.
- The hazard unit stalls any op 1–12 in EX while `busy | (start & op∈{1..4,9..12})` is set on the preceding instruction. The MDU itself does no stalling.
- MTHI/MTLO at edge E0: new value visible at E0. No busy.
- Operands are captured at start. Changes to A/B during BUSY have no effect.

## Configuration
- `MDU_MADD_EN` defined: adds ops 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
  - Result is {HI,LO} ± product, signed or unsigned per op, 64-bit wrap-around.
  - The accumulate base is the {HI,LO} value at start.
  - Latency is MUL_CYCLES.
- Undefined: ops 9–15 behave as NONE.

## Structure
- Shared defines/package `mdu_defs`: the 4-bit op codes (`MDU_NONE` … `MDU_MSUBU`) and the default latencies. EX control and the hazard unit use the same constants.
- One natural sub-module, `mdu_arith`: combinational A/B/op/{HI,LO} → 64-bit result, including the divide-by-zero keep rule. The `mdu` top holds the FSM, counter, pending, HI and LO.

## Test plan
- Reset → HI=LO=0, busy=0. Then MULT A=0xFFFFFFFE (−2), B=3 → busy for 5 cycles; after that {HI,LO} = 0xFFFFFFFF_FFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=−7, B=2 → busy for 10 cycles; then LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU A=7, B=0 → 10 busy cycles, HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0. MTHI A=0x12345678 → HI=0x12345678 after one edge, busy never rises.
- DIVU started, then reset asserted at busy cycle 4 → busy=0 immediately; HI/LO=0, with no late writeback after reset release.
- With `MDU_MADD_EN`: HI=0, LO=0xFFFFFFFF, then MADDU A=1, B=1 → {HI,LO}=0x00000001_00000000. Without the macro, op 10 leaves all state unchanged.
